// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: debounces the direction buttons into a reversal-safe direction bus and
// divides vga_clk into the update_clk game tick. Optional pause button: SNAKE_PAUSE_EN.
`ifndef LEFT_DIR
`define LEFT_DIR  2'b00
`endif
`ifndef TOP_DIR
`define TOP_DIR   2'b01
`endif
`ifndef RIGHT_DIR
`define RIGHT_DIR 2'b10
`endif
`ifndef DOWN_DIR
`define DOWN_DIR  2'b11
`endif

module snake_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned TICK_DIV        = 5000000
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       btn_left,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       game_over,
  input  logic       game_won,
`ifdef SNAKE_PAUSE_EN
  input  logic       btn_pause,
  output logic       paused,
`endif
  output logic [1:0] direction,
  output logic       update_clk
);

`ifdef SNAKE_PAUSE_EN
  localparam int unsigned NBTN = 5;
`else
  localparam int unsigned NBTN = 4;
`endif
  localparam int unsigned CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICK_DIV / 2);
  // Index order is also the request priority: left > up > right > down.
  localparam logic [1:0] BTN_DIR [4] = '{`LEFT_DIR, `TOP_DIR, `RIGHT_DIR, `DOWN_DIR};

  logic [NBTN-1:0] raw_c;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] stable;
  logic [NBTN-1:0] stable_q;
  logic [NBTN-1:0] press_c;
  logic [CW-1:0]   cnt [NBTN];
  logic [TW-1:0]   tick_cnt;
  logic [1:0]      pending;
  logic [1:0]      opp_c;
  logic [1:0]      sel_dir_c;
  logic            sel_valid_c;
  logic            hold_c;
  logic            commit_c;

`ifdef SNAKE_PAUSE_EN
  logic pause_req;
  assign raw_c = {btn_pause, btn_down, btn_right, btn_up, btn_left};
`else
  assign raw_c = {btn_down, btn_right, btn_up, btn_left};
`endif

  function automatic logic [1:0] opposite(input logic [1:0] d);
    logic [1:0] o;
    case (d)
      `LEFT_DIR:  o = `RIGHT_DIR;
      `RIGHT_DIR: o = `LEFT_DIR;
      `TOP_DIR:   o = `DOWN_DIR;
      default:    o = `TOP_DIR;
    endcase
    return o;
  endfunction

  // Synchronise and debounce every button; stable flips after DEBOUNCE_CYCLES differing samples.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int unsigned i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw_c;
      sync2    <= sync1;
      stable_q <= stable;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press_c = stable & ~stable_q;

  // Highest-priority press that is not a reversal of the committed direction.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_dir_c   = `RIGHT_DIR;
    opp_c       = opposite(direction);
    for (int i = 3; i >= 0; i--) begin
      if (press_c[i] && (BTN_DIR[i] != opp_c)) begin
        sel_valid_c = 1'b1;
        sel_dir_c   = BTN_DIR[i];
      end
    end
  end

`ifdef SNAKE_PAUSE_EN
  assign hold_c = game_over | game_won | paused;
`else
  assign hold_c = game_over | game_won;
`endif
  assign commit_c = (tick_cnt == TICK_HALF);

  // Pending/direction registers and the tick divider; commit lands on the update_clk fall.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      direction  <= `RIGHT_DIR;
      pending    <= `RIGHT_DIR;
      tick_cnt   <= '0;
      update_clk <= 1'b0;
`ifdef SNAKE_PAUSE_EN
      pause_req  <= 1'b0;
      paused     <= 1'b0;
`endif
    end else begin
      if (!hold_c && sel_valid_c) pending <= sel_dir_c;
      if (!hold_c && commit_c) direction <= pending;
`ifdef SNAKE_PAUSE_EN
      if (!(game_over | game_won) && press_c[4]) pause_req <= ~pause_req;
      if (commit_c) paused <= pause_req;
      if (paused) begin
        tick_cnt   <= TICK_HALF;
        update_clk <= 1'b0;
      end else begin
        tick_cnt   <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
        update_clk <= (tick_cnt < TICK_HALF);
      end
`else
      tick_cnt   <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
      update_clk <= (tick_cnt < TICK_HALF);
`endif
    end
  end

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Testbench for snake_input_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a behavioural model of the debounce/commit rules.
module tb_snake_input_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TD   = 16;
  localparam int unsigned HALF = TD / 2;
  localparam logic [1:0] L = 2'd0, T = 2'd1, R = 2'd2, D = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_left, btn_up, btn_right, btn_down;
  logic       game_over, game_won;
  logic [1:0] direction;
  logic       update_clk;

  int vectors = 0;
  int miscompares = 0;

  snake_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TD)) dut (
    .vga_clk(clk), .reset_n(reset_n),
    .btn_left(btn_left), .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down),
    .game_over(game_over), .game_won(game_won),
    .direction(direction), .update_clk(update_clk)
  );

  always #5 clk = ~clk;

  // Reference model: n counts clock edges since reset release; a button level is accepted
  // after DEB consecutive synchronised samples that disagree with the accepted level.
  int         n;
  bit   [3:0] s1, s2, stab, prevstab;
  int         run [4];
  logic [1:0] m_dir, m_pend;
  logic       m_uclk;
  logic [1:0] opp [4] = '{R, D, L, T};

  always @(posedge clk) begin
    bit [3:0]   press;
    bit         frozen, found;
    logic [1:0] nd;
    if (!reset_n) begin
      n = 0; s1 = '0; s2 = '0; stab = '0; prevstab = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      m_dir = R; m_pend = R; m_uclk = 1'b0;
    end else begin
      n++;
      press  = stab & ~prevstab;
      frozen = game_over | game_won;
      nd = (((n - 1) % TD) == HALF && !frozen) ? m_pend : m_dir;
      found = 1'b0;
      if (!frozen)
        for (int i = 0; i < 4; i++)
          if (!found && press[i] && (2'(i) != opp[m_dir])) begin
            m_pend = 2'(i);
            found  = 1'b1;
          end
      m_dir  = nd;
      m_uclk = ((n - 1) % TD) < HALF;
      prevstab = stab;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != stab[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            stab[i] = ~stab[i];
            run[i]  = 0;
          end
        end else run[i] = 0;
      end
      s2 = s1;
      s1 = {btn_down, btn_right, btn_up, btn_left};
    end
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk("direction", 4'(direction), 4'(m_dir));
      chk("update_clk", 4'(update_clk), 4'(m_uclk));
    end
  endtask

  // Advance to the first falling edge of update_clk (the commit point), bounded.
  task automatic wait_fall();
    logic prev;
    bit   seen;
    seen = 1'b0;
    prev = update_clk;
    for (int k = 0; k < 2 * TD && !seen; k++) begin
      step(1);
      if (prev === 1'b1 && update_clk === 1'b0) seen = 1'b1;
      prev = update_clk;
    end
    chk("commit_wait", 4'(seen), 4'd1);
  endtask

  initial begin
    int edges;
    logic prev;
    reset_n = 1'b0;
    {btn_left, btn_up, btn_right, btn_down} = '0;
    game_over = 1'b0;
    game_won  = 1'b0;

    step(3);
    chk("rst_dir", 4'(direction), 4'(R));
    chk("rst_uclk", 4'(update_clk), 4'd0);
    reset_n = 1'b1;

    // 8 high / 8 low from the first edge after release
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("duty", 4'(update_clk), 4'((k % TD) < HALF));
      chk("duty_dir", 4'(direction), 4'(R));
    end

    // Short glitch on down never becomes a press
    btn_down = 1'b1; step(3); btn_down = 1'b0;
    step(2 * TD);
    chk("glitch", 4'(direction), 4'(R));

    // Reversal request is discarded
    btn_left = 1'b1; step(3 * TD);
    chk("reversal", 4'(direction), 4'(R));
    btn_left = 1'b0; step(8);

    // Bouncing up settles into a single press
    wait_fall();
    for (int k = 0; k < 10; k++) begin
      btn_up = ~btn_up; step(2);
    end
    btn_up = 1'b1; step(7);
    wait_fall();
    chk("bounce", 4'(direction), 4'(T));
    btn_up = 1'b0; step(8);

    btn_right = 1'b1; step(8); btn_right = 1'b0;
    wait_fall();
    chk("right_back", 4'(direction), 4'(R));
    step(8);

    // Left (reversal) and up together: up wins
    wait_fall();
    btn_left = 1'b1; btn_up = 1'b1; step(8);
    btn_left = 1'b0; btn_up = 1'b0;
    wait_fall();
    chk("priority", 4'(direction), 4'(T));
    step(8);

    btn_right = 1'b1; step(8); btn_right = 1'b0;
    wait_fall();
    chk("right_back2", 4'(direction), 4'(R));
    step(8);

    // Up then down before one commit: last legal request wins
    wait_fall();
    btn_up = 1'b1; step(2);
    btn_down = 1'b1; step(8);
    btn_up = 1'b0; btn_down = 1'b0;
    wait_fall();
    chk("overwrite", 4'(direction), 4'(D));
    step(8);

    // Frozen: presses ignored, tick keeps toggling
    game_over = 1'b1; step(2);
    btn_left = 1'b1; step(10); btn_left = 1'b0;
    btn_down = 1'b1; step(10); btn_down = 1'b0;
    edges = 0;
    prev = update_clk;
    for (int k = 0; k < 2 * TD; k++) begin
      step(1);
      if (update_clk !== prev) edges++;
      prev = update_clk;
    end
    chk("freeze_toggles", 4'(edges), 4'd4);
    chk("freeze_dir", 4'(direction), 4'(D));
    game_over = 1'b0; step(TD);
    chk("unfreeze_dir", 4'(direction), 4'(D));

    // Random button traffic, freezes and mid-operation resets
    for (int s = 0; s < 70; s++) begin
      {btn_down, btn_right, btn_up, btn_left} = 4'($urandom);
      game_over = ($urandom_range(0, 7) == 0);
      game_won  = ($urandom_range(0, 9) == 0);
      reset_n   = ($urandom_range(0, 19) != 0);
      step($urandom_range(1, 14));
    end
    reset_n = 1'b1;
    {btn_left, btn_up, btn_right, btn_down} = '0;
    game_over = 1'b0; game_won = 1'b0;
    step(2 * TD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
